// File: rtl/act_layer_stream.sv
// act_layer_stream: applies a runtime-selected activation (pass, ReLU,
// leaky ReLU, ELU) to a CH x POS fixed-point tensor, LANES elements per
// clock through a two-stage pipeline, wrapped in a level load/valid job
// handshake.
//
// Handshake: load is a level request. A high load sampled in IDLE captures
// d and mode and starts a job (busy=1). Dropping load while the job is
// running aborts it. When the whole tensor has been written, busy falls and
// valid rises; valid and q then hold for as long as load stays high. Load
// sampled low in DONE clears valid, and the next job needs load to be seen
// low for at least one cycle first.
module act_layer_stream #(
  parameter int DATA_LEN = 18,
  parameter int CH       = 32,
  parameter int POS      = 12,
  parameter int LANES    = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       load,
  input  logic [1:0]                 mode,
  input  logic [CH*POS*DATA_LEN-1:0] d,
  output logic                       busy,
  output logic                       valid,
  output logic [CH*POS*DATA_LEN-1:0] q
);

  localparam int W   = DATA_LEN;
  localparam int TOT = CH * POS;
  localparam int N   = TOT / LANES;
  localparam int CW  = (N > 1) ? $clog2(N) : 1;
  localparam int EW  = (TOT > 1) ? $clog2(TOT) : 1;
  localparam int PW  = 23;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [1:0]      dcnt;

  logic [W-1:0]    in_mem [TOT];
  logic [W-1:0]    q_mem  [TOT];
  logic [1:0]      mode_r;

  // Stage-1 combinational inputs (per lane)
  logic signed [W-1:0]  c_x    [LANES];
  logic [W-1:0]         c_mneg [LANES];
  logic [31:0]          c_mx   [LANES];
  logic                 c_sat  [LANES];
  logic [2:0]           c_seg  [LANES];
  logic signed [11:0]   c_diff [LANES];
  logic signed [PW-1:0] c_prod [LANES];

  // Stage-1 registers
  logic                 s1_vld;
  logic [CW-1:0]        s1_grp;
  logic [1:0]           s1_mode;
  logic signed [W-1:0]  s1_x    [LANES];
  logic                 s1_sat  [LANES];
  logic [2:0]           s1_seg  [LANES];
  logic signed [PW-1:0] s1_prod [LANES];

  // Stage-2 combinational result and registers
  logic signed [PW-1:0] c_sum [LANES];
  logic signed [W-1:0]  c_y   [LANES];
  logic                 s2_vld;
  logic [CW-1:0]        s2_grp;
  logic signed [W-1:0]  s2_y  [LANES];

  // ELU breakpoints at integer steps of -1.0, in units of 2^-10
  function automatic logic signed [11:0] e_lut(input logic [3:0] idx);
    case (idx)
      4'd0:    return 12'sd0;
      4'd1:    return -12'sd647;
      4'd2:    return -12'sd885;
      4'd3:    return -12'sd973;
      4'd4:    return -12'sd1005;
      4'd5:    return -12'sd1017;
      4'd6:    return -12'sd1021;
      4'd7:    return -12'sd1023;
      default: return -12'sd1024;
    endcase
  endfunction

  // Job control FSM: issue counter, drain counter and registered busy/valid
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      dcnt  <= '0;
      busy  <= 1'b0;
      valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (load) begin
            state <= RUN;
            cnt   <= '0;
            busy  <= 1'b1;
          end
        end
        RUN: begin
          if (!load) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else if (cnt == CW'(N - 1)) begin
            state <= DRAIN;
            dcnt  <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DRAIN: begin
          if (!load) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else if (dcnt == 2'd2) begin
            state <= DONE;
            busy  <= 1'b0;
            valid <= 1'b1;
          end else begin
            dcnt <= dcnt + 1'b1;
          end
        end
        default: begin
          if (!load) begin
            state <= IDLE;
            valid <= 1'b0;
          end
        end
      endcase
    end
  end

  // Capture the input tensor and mode when a job is accepted
  always_ff @(posedge clk) begin
    if (!rst && state == IDLE && load) begin
      for (int k = 0; k < TOT; k++) in_mem[k] <= d[k*W +: W];
      mode_r <= mode;
    end
  end

  // Stage-1 logic: split each negative input into segment and fraction
  always_comb begin
    for (int l = 0; l < LANES; l++) begin
      c_x[l]    = $signed(in_mem[EW'(cnt) * EW'(LANES) + EW'(l)]);
      c_mneg[l] = W'(0) - $unsigned(c_x[l]);
      c_mx[l]   = 32'(c_mneg[l]);
      c_sat[l]  = c_mx[l] >= 32'd8192;
      c_seg[l]  = c_mx[l][12:10];
      c_diff[l] = e_lut({1'b0, c_seg[l]} + 4'd1) - e_lut({1'b0, c_seg[l]});
      c_prod[l] = PW'(c_diff[l]) * $signed({13'd0, c_mx[l][9:0]});
    end
  end

  // Stage-1 data registers (qualified by s1_vld, so no reset needed)
  always_ff @(posedge clk) begin
    s1_grp  <= cnt;
    s1_mode <= mode_r;
    for (int l = 0; l < LANES; l++) begin
      s1_x[l]    <= c_x[l];
      s1_sat[l]  <= c_sat[l];
      s1_seg[l]  <= c_seg[l];
      s1_prod[l] <= c_prod[l];
    end
  end

  // Stage-2 logic: interpolate, saturate and select by mode
  always_comb begin
    for (int l = 0; l < LANES; l++) begin
      c_sum[l] = PW'(e_lut({1'b0, s1_seg[l]})) + (s1_prod[l] >>> 10);
      c_y[l]   = s1_x[l];
      case (s1_mode)
        2'd0: c_y[l] = s1_x[l];
        2'd1: if (s1_x[l] < 0) c_y[l] = '0;
        2'd2: if (s1_x[l] < 0) c_y[l] = s1_x[l] >>> 3;
        default: begin
          if (s1_x[l] < 0) c_y[l] = s1_sat[l] ? W'(-32'sd1024) : W'(c_sum[l]);
        end
      endcase
    end
  end

  // Stage-2 data registers
  always_ff @(posedge clk) begin
    s2_grp <= s1_grp;
    for (int l = 0; l < LANES; l++) s2_y[l] <= c_y[l];
  end

  // Pipeline valids and the output tensor write-back
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_vld <= 1'b0;
      s2_vld <= 1'b0;
      for (int k = 0; k < TOT; k++) q_mem[k] <= '0;
    end else begin
      s1_vld <= (state == RUN) && load;
      s2_vld <= s1_vld;
      if (s2_vld) begin
        for (int l = 0; l < LANES; l++)
          q_mem[EW'(s2_grp) * EW'(LANES) + EW'(l)] <= s2_y[l];
      end
    end
  end

  // Flatten the output tensor onto the q port
  always_comb begin
    q = '0;
    for (int k = 0; k < TOT; k++) q[k*W +: W] = q_mem[k];
  end

endmodule

// File: tb/tb_act_layer_stream.sv
// tb_act_layer_stream: randomized jobs through act_layer_stream, checked
// element by element against an integer model of the activation rules.
module tb_act_layer_stream;

  localparam int W     = 18;
  localparam int CH    = 32;
  localparam int POS   = 12;
  localparam int LANES = 4;
  localparam int TOT   = CH * POS;
  localparam int N     = TOT / LANES;

  logic               clk;
  logic               rst;
  logic               load;
  logic [1:0]         mode_in;
  logic [TOT*W-1:0]   d_in;
  logic               busy;
  logic               valid;
  logic [TOT*W-1:0]   q;

  logic [W-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  act_layer_stream #(.DATA_LEN(W), .CH(CH), .POS(POS), .LANES(LANES)) dut (
    .clk(clk), .rst(rst), .load(load), .mode(mode_in), .d(d_in),
    .busy(busy), .valid(valid), .q(q)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input int obs, input int exp_v);
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  function automatic int sx(input logic [W-1:0] v);
    return int'($signed(v));
  endfunction

  // Reference activation, straight from the piecewise definition
  function automatic int act_ref(input int x, input int md);
    int e[9] = '{0, -647, -885, -973, -1005, -1017, -1021, -1023, -1024};
    int m, i, f;
    case (md)
      0: return x;
      1: return (x < 0) ? 0 : x;
      2: return (x < 0) ? (x >>> 3) : x;
      default: begin
        if (x >= 0) return x;
        m = -x;
        i = m / 1024;
        f = m % 1024;
        if (i >= 8) return -1024;
        return e[i] + (((e[i+1] - e[i]) * f) >>> 10);
      end
    endcase
  endfunction

  function automatic logic [W-1:0] rand_elem();
    int r;
    case ($urandom_range(0, 3))
      0: r = int'($urandom_range(0, 24000)) - 12000;
      1: r = int'($urandom_range(0, 4000)) - 2000;
      2: r = int'($urandom);
      default: begin
        case ($urandom_range(0, 3))
          0: r = -(1 << (W - 1));
          1: r = (1 << (W - 1)) - 1;
          2: r = 0;
          default: r = -1;
        endcase
      end
    endcase
    return W'(r);
  endfunction

  // driver tasks
  task automatic set_elem(input int k, input int v);
    d_in[k*W +: W] = W'(v);
  endtask

  task automatic fill_rand();
    for (int k = 0; k < TOT; k++) d_in[k*W +: W] = rand_elem();
  endtask

  task automatic start_job(input logic [1:0] md);
    mode_in = md;
    load    = 1'b1;
    exp_q.delete();
    for (int k = 0; k < TOT; k++)
      exp_q.push_back(W'(act_ref(sx(d_in[k*W +: W]), int'(md))));
    tick();
    chk("busy_after_t0", int'(busy), 1);
    chk("valid_after_t0", int'(valid), 0);
  endtask

  task automatic wait_valid(input bit scramble);
    int lat = 0;
    while (!valid && lat < 300) begin
      if (scramble) begin
        fill_rand();
        mode_in = 2'($urandom_range(0, 3));
      end
      tick();
      lat++;
      if (lat == N + 2) chk("busy_before_done", int'(busy), 1);
    end
    chk("valid_latency", lat, N + 3);
    chk("busy_at_done", int'(busy), 0);
  endtask

  // scoreboard: compare the whole q tensor with the expected queue
  task automatic check_q(input string tag);
    int nbad = 0;
    int first = -1;
    for (int k = 0; k < TOT; k++) begin
      if (q[k*W +: W] !== exp_q[k]) begin
        if (first < 0) first = k;
        nbad++;
      end
    end
    if (first >= 0) chk({tag, "_first_elem"}, sx(q[first*W +: W]), sx(exp_q[first]));
    chk({tag, "_bad_elems"}, nbad, 0);
  endtask

  task automatic chk_elem(input string tag, input int k, input int exp_v);
    chk(tag, sx(q[k*W +: W]), exp_v);
  endtask

  task automatic finish_job(input bit scramble, input int hold);
    repeat (hold) begin
      if (scramble) begin
        fill_rand();
        mode_in = 2'($urandom_range(0, 3));
      end
      tick();
      chk("valid_hold", int'(valid), 1);
      chk("busy_hold", int'(busy), 0);
    end
    check_q("q_hold");
    load = 1'b0;
    tick();
    chk("valid_after_drop", int'(valid), 0);
    chk("busy_after_drop", int'(busy), 0);
    check_q("q_retained");
  endtask

  task automatic count_nonzero(input string tag);
    int nz = 0;
    for (int k = 0; k < TOT; k++) if (q[k*W +: W] !== '0) nz++;
    chk(tag, nz, 0);
  endtask

  initial begin
    rst = 1'b1; load = 1'b0; mode_in = 2'd0; d_in = '0;
    tick();
    tick();
    chk("rst_busy", int'(busy), 0);
    chk("rst_valid", int'(valid), 0);
    count_nonzero("rst_q_nonzero");
    rst = 1'b0;
    tick();

    // base case: twelve 1.0 values, ELU leaves them untouched
    d_in = '0;
    for (int k = 0; k < 12; k++) set_elem(k, 1024);
    start_job(2'd3);
    wait_valid(1'b0);
    check_q("base");
    chk_elem("base_e0", 0, 1024);
    chk_elem("base_e12", 12, 0);
    finish_job(1'b0, 3);

    // ELU negatives and boundaries
    fill_rand();
    set_elem(0, -1024); set_elem(1, -512); set_elem(2, -2048);
    set_elem(3, -10240); set_elem(4, -131072); set_elem(5, 300);
    start_job(2'd3);
    wait_valid(1'b0);
    check_q("elu");
    chk_elem("elu_m1024", 0, -647);
    chk_elem("elu_m512", 1, -324);
    chk_elem("elu_m2048", 2, -885);
    chk_elem("elu_m10240", 3, -1024);
    chk_elem("elu_min", 4, -1024);
    chk_elem("elu_pos", 5, 300);
    finish_job(1'b0, 1);

    // ReLU and leaky ReLU directed values
    for (int md = 1; md <= 2; md++) begin
      fill_rand();
      set_elem(0, -5); set_elem(1, -9); set_elem(2, -1024); set_elem(3, 777);
      start_job(2'(md));
      wait_valid(1'b0);
      check_q("relu");
      chk_elem("relu_m5", 0, (md == 1) ? 0 : -1);
      chk_elem("relu_m9", 1, (md == 1) ? 0 : -2);
      chk_elem("relu_m1024", 2, (md == 1) ? 0 : -128);
      chk_elem("relu_777", 3, 777);
      finish_job(1'b0, 1);
    end

    // pass-through plus random jobs in random modes
    fill_rand();
    start_job(2'd0);
    wait_valid(1'b0);
    check_q("pass");
    finish_job(1'b0, 1);
    repeat (4) begin
      fill_rand();
      start_job(2'($urandom_range(0, 3)));
      wait_valid(1'b0);
      check_q("rand");
      finish_job(1'b0, 2);
    end

    // abort at t0+40, then restart two cycles later
    fill_rand();
    start_job(2'd3);
    repeat (39) tick();
    load = 1'b0;
    tick();
    chk("abort_busy", int'(busy), 0);
    chk("abort_valid", int'(valid), 0);
    tick();
    chk("abort_valid_idle", int'(valid), 0);
    fill_rand();
    start_job(2'd2);
    wait_valid(1'b0);
    check_q("after_abort");
    finish_job(1'b0, 1);

    // reset mid-job with load held high
    fill_rand();
    start_job(2'd3);
    repeat (49) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_valid", int'(valid), 0);
    count_nonzero("midrst_q_nonzero");
    start_job(2'd3);
    wait_valid(1'b0);
    check_q("after_rst");
    finish_job(1'b0, 1);

    // inputs change every cycle after t0; no second job while load stays high
    fill_rand();
    start_job(2'd3);
    wait_valid(1'b1);
    check_q("capture");
    finish_job(1'b1, 10);
    fill_rand();
    start_job(2'd1);
    wait_valid(1'b1);
    check_q("rerun");
    finish_job(1'b0, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
